// File: rtl/ram_stream_reader_pkg.sv
// Shared types and width defaults for the RAM read-side streaming client.
package ram_stream_reader_pkg;

  localparam int DEF_SRAM_WIDTH = 256;
  localparam int DEF_SRAM_WORD  = 64;
  localparam int FIFO_DEPTH     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Two-entry register FIFO used as the skid buffer behind the RAM read port.
module skid_fifo2
  import ram_stream_reader_pkg::*;
#(
  parameter int W = DEF_SRAM_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  logic [FIFO_DEPTH-1:0][W-1:0] mem;
  logic                         wr_ptr, rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'(FIFO_DEPTH));

  // Push-with-pop while full is safe: the slot written is the one being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: issues RAM reads (1-cycle latency) and streams words out
// through a 2-entry skid FIFO, only issuing when a slot is guaranteed.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int SRAM_WIDTH = DEF_SRAM_WIDTH,
  parameter int SRAM_WORD  = DEF_SRAM_WORD,
  parameter int ADDR_WIDTH = $clog2(SRAM_WORD),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [SRAM_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SRAM_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int DW = SRAM_WIDTH + 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  last_tag, inflight, inflight_last;
  logic [DW-1:0]         head;
  logic [1:0]            fifo_count;
  logic                  fifo_empty, fifo_full;
  logic                  pop, issue_ok;
  logic [2:0]            occ;

  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(SRAM_WORD - 1)) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  assign cmd_ready             = (state == ST_IDLE);
  assign busy                  = (state != ST_IDLE);
  assign out_valid             = !fifo_empty;
  assign {out_last, out_data}  = head;
  assign pop                   = out_valid && out_ready;

  // Credit counts every word already owed to the FIFO: queued, returning on
  // rd_data, and the read on the RAM port right now. Ready can drop at any
  // time, so only a pop already happening can be counted on.
  assign occ      = {1'b0, fifo_count} + {2'b0, inflight} + {2'b0, rd_en};
  assign issue_ok = occ < (3'(FIFO_DEPTH) + {2'b0, pop});

  skid_fifo2 #(.W(DW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data({inflight_last, rd_data}),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      nxt_addr      <= '0;
      remaining     <= '0;
      last_tag      <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en && last_tag;
      rd_en         <= 1'b0;
      last_tag      <= 1'b0;
      case (state)
        ST_IDLE: begin
          // First read goes out in the handshake cycle itself; FIFO is empty here.
          if (cmd_valid && cmd_len != '0) begin
            rd_en     <= 1'b1;
            rd_addr   <= cmd_addr;
            nxt_addr  <= wrap_inc(cmd_addr);
            remaining <= cmd_len - LEN_WIDTH'(1);
            last_tag  <= (cmd_len == LEN_WIDTH'(1));
            state     <= (cmd_len == LEN_WIDTH'(1)) ? ST_DRAIN : ST_READ;
          end
        end
        ST_READ: begin
          if (issue_ok && remaining != '0) begin
            rd_en     <= 1'b1;
            rd_addr   <= nxt_addr;
            nxt_addr  <= wrap_inc(nxt_addr);
            remaining <= remaining - LEN_WIDTH'(1);
            last_tag  <= (remaining == LEN_WIDTH'(1));
            if (remaining == LEN_WIDTH'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!rd_en && !inflight && fifo_empty) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(inflight && fifo_full && !pop));
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a 1-cycle-latency RAM model.
module tb_ram_stream_reader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [5:0]   cmd_addr = '0;
  logic [6:0]   cmd_len = '0;
  logic         rd_en;
  logic [5:0]   rd_addr;
  logic [255:0] rd_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] out_data;
  logic         out_last;
  logic         busy;

  int total = 0;
  int bad = 0;
  int issued = 0;
  int popped = 0;
  logic [255:0] dq[$];
  logic         lq[$];
  logic [5:0]   aq[$];
  logic         prev_stall = 1'b0;
  logic [255:0] prev_data = '0;
  logic         prev_last = 1'b0;

  ram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [255:0] mw(input int i);
    logic [31:0] w;
    w = 32'h5A00_0000 + 32'(i);
    return {8{w}};
  endfunction

  always_ff @(posedge clk) if (rd_en) rd_data <= mw(int'(rd_addr));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: records handshakes and read issues, checks stall hold and credit.
  initial forever begin
    @(negedge clk);
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", 256'(out_valid), 256'(1));
        chk("stall_data", out_data, prev_data);
        chk("stall_last", 256'(out_last), 256'(prev_last));
      end
      if (rd_en) begin
        aq.push_back(rd_addr);
        issued++;
        chk("no_overrun", 256'(issued - popped <= 2), 256'(1));
      end
      if (out_valid && out_ready) begin
        dq.push_back(out_data);
        lq.push_back(out_last);
        popped++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    dq.delete(); lq.delete(); aq.delete();
    issued = 0; popped = 0;
  endtask

  task automatic send_cmd(input int addr, input int len);
    chk("cmd_ready_idle", 256'(cmd_ready), 256'(1));
    cmd_valid = 1'b1;
    cmd_addr  = 6'(addr);
    cmd_len   = 7'(len);
    tick();
    cmd_valid = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating
  task automatic wait_idle(input int mode);
    for (int n = 0; n < 400 && busy; n++) begin
      out_ready = (mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
      tick();
    end
    chk("idle_timeout", 256'(busy), 256'(0));
    out_ready = 1'b1;
  endtask

  task automatic check_burst(input int base, input int len);
    chk("n_words", 256'(dq.size()), 256'(len));
    chk("n_reads", 256'(aq.size()), 256'(len));
    for (int i = 0; i < len; i++) begin
      if (i < dq.size()) begin
        chk("data", dq[i], mw((base + i) % 64));
        chk("last", 256'(lq[i]), 256'(i == len - 1));
      end
      if (i < aq.size()) chk("addr", 256'(aq[i]), 256'((base + i) % 64));
    end
  endtask

  initial begin
    #1;
    chk("rst_rd_en", 256'(rd_en), 256'(0));
    chk("rst_rd_addr", 256'(rd_addr), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_data", out_data, 256'(0));
    chk("rst_out_last", 256'(out_last), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_cmd_ready", 256'(cmd_ready), 256'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // burst 0/4 with ready high, latency check
    clear_mon();
    send_cmd(0, 4);
    chk("t1_rd_en_c0", 256'(rd_en), 256'(1));
    chk("t1_rd_addr_c0", 256'(rd_addr), 256'(0));
    chk("t1_busy_c0", 256'(busy), 256'(1));
    chk("t1_cmd_ready_c0", 256'(cmd_ready), 256'(0));
    tick();
    chk("t1_valid_c1", 256'(out_valid), 256'(0));
    tick();
    chk("t1_valid_c2", 256'(out_valid), 256'(1));
    chk("t1_data_c2", out_data, mw(0));
    wait_idle(0);
    check_burst(0, 4);
    chk("t1_cmd_ready_end", 256'(cmd_ready), 256'(1));

    // burst 0/8 with ready toggling
    clear_mon();
    send_cmd(0, 8);
    wait_idle(1);
    check_burst(0, 8);

    // wrap around the top of memory
    clear_mon();
    send_cmd(62, 4);
    wait_idle(0);
    check_burst(62, 4);

    // zero-length command
    clear_mon();
    send_cmd(5, 0);
    chk("t4_busy", 256'(busy), 256'(0));
    chk("t4_cmd_ready", 256'(cmd_ready), 256'(1));
    chk("t4_rd_en", 256'(rd_en), 256'(0));
    repeat (4) tick();
    chk("t4_reads", 256'(aq.size()), 256'(0));
    chk("t4_words", 256'(dq.size()), 256'(0));
    chk("t4_valid", 256'(out_valid), 256'(0));

    // ready held low: only two reads fit
    clear_mon();
    out_ready = 1'b0;
    send_cmd(20, 16);
    repeat (10) tick();
    chk("t5_reads_stalled", 256'(aq.size()), 256'(2));
    chk("t5_valid_stalled", 256'(out_valid), 256'(1));
    chk("t5_head_stalled", out_data, mw(20));
    wait_idle(0);
    check_burst(20, 16);

    // reset mid-burst after 5 words
    clear_mon();
    send_cmd(0, 16);
    for (int n = 0; n < 100 && dq.size() < 5; n++) tick();
    chk("t6_reach5", 256'(dq.size() >= 5), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_rd_en", 256'(rd_en), 256'(0));
    chk("t6_rd_addr", 256'(rd_addr), 256'(0));
    chk("t6_valid", 256'(out_valid), 256'(0));
    chk("t6_data", out_data, 256'(0));
    chk("t6_last", 256'(out_last), 256'(0));
    chk("t6_busy", 256'(busy), 256'(0));
    chk("t6_cmd_ready", 256'(cmd_ready), 256'(1));
    tick();
    rst_n = 1'b1;
    tick();
    clear_mon();
    send_cmd(10, 2);
    wait_idle(0);
    check_burst(10, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
